// File: rtl/textmode_pkg.sv
// textmode_pkg: screen geometry, control codes and console state shared by the console and the GPU.
package textmode_pkg;
  localparam int FONT_W = 8;
  localparam int FONT_H = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int DEF_COLS = SCREEN_W / FONT_W;
  localparam int DEF_ROWS = SCREEN_H / FONT_H;
  localparam int SB_NWORDS = DEF_COLS * DEF_ROWS / 4;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  typedef enum logic [1:0] {ST_IDLE, ST_PUT, ST_CLR_LINE, ST_CLR_ALL} con_state_e;
endpackage

// File: rtl/sb_write_port.sv
// sb_write_port: single-outstanding bus write; holds a request until m_ready, then idles one cycle.
module sb_write_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  mask_i,
  input  logic        m_ready_i,
  output logic        done_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wmask_o,
  output logic        m_wen_o
);
  assign done_o = m_wen_o & m_ready_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wen_o <= 1'b0;
      m_addr_o <= '0;
      m_wdata_o <= '0;
      m_wmask_o <= '0;
    end else if (done_o) begin
      m_wen_o <= 1'b0;
    end else if (!m_wen_o && req_i) begin
      m_wen_o <= 1'b1;
      m_addr_o <= addr_i;
      m_wdata_o <= data_i;
      m_wmask_o <= mask_i;
    end
  end
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: byte-stream console driving the textmode screenbuffer.
// Define TEXT_CONSOLE_AUTOCLEAR_EN to blank every new line with CLR_LINE.
module text_console_ctrl
  import textmode_pkg::*;
#(
  parameter logic [31:0] SCREENBUFFER_BASE_ADDR = 32'h8000,
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear_req,
  output logic        busy,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  output logic        m_wen,
  input  logic        m_ready,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);
`ifdef TEXT_CONSOLE_AUTOCLEAR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif
  localparam logic [9:0] LAST_WORD = 10'(ROWS * COLS / 4 - 1);
  localparam logic [9:0] LINE_WORDS = 10'(COLS / 4);
  con_state_e state_q;
  logic [4:0] row_q, nrow;
  logic [6:0] col_q;
  logic [9:0] cnt_q, cur_line, nline, line_last, req_word;
  logic [11:0] idx, bidx;
  logic bs_q, is_ctrl, accept, do_glyph, do_bs, do_lf, do_clr_all, in_clr, req, done;
  logic [31:0] req_data;
  logic [3:0] req_mask;
  function automatic logic [9:0] line_word(input logic [4:0] r);
    return (COLS == 80) ? 10'({r, 4'd0}) + 10'({r, 2'd0}) : 10'(r * (COLS / 4));
  endfunction
  assign char_ready = (state_q == ST_IDLE) & ~clear_req;
  assign busy = state_q != ST_IDLE;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  always_comb begin
    nrow = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
    cur_line = line_word(row_q);
    nline = line_word(nrow);
    line_last = cur_line + LINE_WORDS - 10'd1;
    idx = {cur_line, 2'b00} + 12'(col_q);
    bidx = idx - 12'd1;
    is_ctrl = char_in inside {CH_BS, CH_LF, CH_FF, CH_CR};
    accept = char_valid & char_ready;
    do_clr_all = (state_q == ST_IDLE) & (clear_req | (char_valid & (char_in == CH_FF)));
    do_glyph = accept & ~is_ctrl;
    do_bs = accept & (char_in == CH_BS) & (col_q != 7'd0);
    do_lf = accept & (char_in == CH_LF);
    in_clr = (state_q == ST_CLR_LINE) | (state_q == ST_CLR_ALL);
    req = do_clr_all | do_glyph | do_bs | (do_lf & AUTOCLR) | (in_clr & ~m_wen);
    req_word = in_clr ? cnt_q : do_clr_all ? 10'd0 : do_lf ? nline : do_bs ? bidx[11:2] : idx[11:2];
    req_data = do_glyph ? {4{char_in}} : {4{CH_SPACE}};
    req_mask = do_glyph ? 4'd1 << idx[1:0] : do_bs ? 4'd1 << bidx[1:0] : 4'hF;
  end
  sb_write_port u_port (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .addr_i(SCREENBUFFER_BASE_ADDR + {20'd0, req_word, 2'd0}),
    .data_i(req_data),
    .mask_i(req_mask),
    .m_ready_i(m_ready),
    .done_o(done),
    .m_addr_o(m_addr),
    .m_wdata_o(m_wdata),
    .m_wmask_o(m_wmask),
    .m_wen_o(m_wen)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      bs_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (do_clr_all) begin
            state_q <= ST_CLR_ALL;
            cnt_q <= '0;
          end else if (accept) begin
            if (char_in == CH_LF) begin
              col_q <= '0;
              row_q <= nrow;
              if (AUTOCLR) begin
                state_q <= ST_CLR_LINE;
                cnt_q <= nline;
              end
            end else if (char_in == CH_CR) begin
              col_q <= '0;
            end else if (char_in == CH_BS) begin
              if (col_q != 7'd0) begin
                col_q <= col_q - 7'd1;
                bs_q <= 1'b1;
                state_q <= ST_PUT;
              end
            end else begin
              bs_q <= 1'b0;
              state_q <= ST_PUT;
            end
          end
        ST_PUT:
          if (done) begin
            state_q <= ST_IDLE;
            // a backspace blanks the cell in place; only glyphs advance the cursor
            if (!bs_q) begin
              if (col_q == 7'(COLS - 1)) begin
                col_q <= '0;
                row_q <= nrow;
                if (AUTOCLR) begin
                  state_q <= ST_CLR_LINE;
                  cnt_q <= nline;
                end
              end else begin
                col_q <= col_q + 7'd1;
              end
            end
          end
        ST_CLR_LINE:
          if (done) begin
            if (cnt_q == line_last) state_q <= ST_IDLE;
            else cnt_q <= cnt_q + 10'd1;
          end
        ST_CLR_ALL:
          if (done) begin
            if (cnt_q == LAST_WORD) begin
              state_q <= ST_IDLE;
              row_q <= '0;
              col_q <= '0;
            end else begin
              cnt_q <= cnt_q + 10'd1;
            end
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed and random byte streams checked against a cell-level console model.
module tb_text_console_ctrl;
  localparam logic [31:0] BASE = 32'h8000;
  localparam int C = 80;
  localparam int R = 30;
`ifdef TEXT_CONSOLE_AUTOCLEAR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic char_valid = 1'b0, clear_req = 1'b0, m_ready = 1'b0;
  logic char_ready, busy, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_wmask;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  wr_t got_q[$], exp_q[$];
  int n_chk = 0, n_fail = 0;
  int mrow = 0, mcol = 0;
  int fixed_lat = 1, cur_lat = 1, wcnt = 0;
  bit spur = 1'b0;
  logic pv_wen = 1'b0;
  wr_t pv;

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .clear_req(clear_req), .busy(busy), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_wen(m_wen), .m_ready(m_ready), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick_lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  // Bus slave: records completed writes and checks hold/gap behaviour on the opposite edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      pv_wen = 1'b0;
      m_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (pv_wen && m_ready) begin
        got_q.push_back(pv);
        chk("gap_after_write", 32'(m_wen), 0);
        cur_lat = pick_lat();
      end else if (pv_wen) begin
        chk("hold_wen", 32'(m_wen), 1);
        chk("hold_addr", m_addr, pv.a);
        chk("hold_data", m_wdata, pv.d);
        chk("hold_mask", 32'(m_wmask), 32'(pv.m));
      end
      if (m_wen) begin
        if (wcnt >= cur_lat) begin
          m_ready = 1'b1;
          wcnt = 0;
        end else begin
          m_ready = 1'b0;
          wcnt++;
        end
      end else begin
        m_ready = spur && ($urandom_range(0, 3) == 0);
        wcnt = 0;
      end
      pv_wen = m_wen;
      pv.a = m_addr;
      pv.d = m_wdata;
      pv.m = m_wmask;
    end
  end

  task automatic put_cell(input int r, input int c, input logic [7:0] ch);
    int b;
    wr_t w;
    b = r * C + c;
    w.a = BASE + 32'(b / 4 * 4);
    w.d = {4{ch}};
    w.m = 4'(1 << (b % 4));
    exp_q.push_back(w);
  endtask

  task automatic fill(input int first_byte, input int nwords);
    wr_t w;
    for (int i = 0; i < nwords; i++) begin
      w.a = BASE + 32'(first_byte + 4 * i);
      w.d = 32'h20202020;
      w.m = 4'hF;
      exp_q.push_back(w);
    end
  endtask

  task automatic newline();
    mcol = 0;
    mrow = (mrow + 1) % R;
    if (AUTO) fill(mrow * C, C / 4);
  endtask

  task automatic model(input logic [7:0] ch);
    case (ch)
      8'h0C: begin fill(0, R * C / 4); mrow = 0; mcol = 0; end
      8'h0A: newline();
      8'h0D: mcol = 0;
      8'h08: if (mcol > 0) begin mcol--; put_cell(mrow, mcol, 8'h20); end
      default: begin
        put_cell(mrow, mcol, ch);
        if (mcol == C - 1) newline();
        else mcol++;
      end
    endcase
  endtask

  task automatic finish_step(input string tag);
    int t;
    wr_t g, e;
    t = 0;
    while ((busy || m_wen) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle_timeout"}, 32'(t < 20000), 1);
    @(negedge clk);
    chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_addr"}, g.a, e.a);
      chk({tag, "_data"}, g.d, e.d);
      chk({tag, "_mask"}, 32'(g.m), 32'(e.m));
    end
    got_q.delete();
    exp_q.delete();
    chk({tag, "_row"}, 32'(cursor_row), 32'(mrow));
    chk({tag, "_col"}, 32'(cursor_col), 32'(mcol));
  endtask

  task automatic send(input logic [7:0] ch, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!char_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_timeout"}, 32'(t < 100), 1);
    char_in = ch;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    model(ch);
    finish_step(tag);
  endtask

  function automatic logic [7:0] rand_glyph();
    logic [7:0] g;
    g = 8'($urandom);
    return (g inside {8'h08, 8'h0A, 8'h0C, 8'h0D}) ? 8'h7E : g;
  endfunction

  initial begin
    int t, r;
    string s;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wen", 32'(m_wen), 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_wmask", 32'(m_wmask), 0);
    chk("rst_row", 32'(cursor_row), 0);
    chk("rst_col", 32'(cursor_col), 0);
    chk("rst_ready", 32'(char_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    send(8'h41, "first_A");
    fixed_lat = 0; cur_lat = 0;
    send(8'h0C, "ff");
    fixed_lat = 5; cur_lat = 5;
    s = "ABCDE";
    for (int i = 0; i < 5; i++) send(8'(s[i]), "abcde");
    fixed_lat = -1; cur_lat = pick_lat(); spur = 1'b1;
    send(8'h0D, "cr");
    send(8'h08, "bs_col0");
    for (int i = 0; i < 3; i++) send(rand_glyph(), "glyph3");
    send(8'h08, "bs_col3");
    send(8'h0D, "cr2");
    for (int i = 0; i < C; i++) send(rand_glyph(), "wrap");
    while (mrow != R - 1) send(8'h0A, "lf_walk");
    send(8'h0A, "lf_wrap");
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      send(r < 8 ? 8'h0A : r < 12 ? 8'h0D : r < 18 ? 8'h08 : rand_glyph(), "random");
    end
    @(negedge clk);
    clear_req = 1'b1;
    char_valid = 1'b1;
    char_in = 8'h5A;
    #1 chk("ready_low_on_clear", 32'(char_ready), 0);
    @(negedge clk);
    clear_req = 1'b0;
    char_valid = 1'b0;
    chk("busy_clr_all", 32'(busy), 1);
    model(8'h0C);
    finish_step("clear_req");
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (40) @(negedge clk);
    t = 0;
    while (!m_wen && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wen_before_reset", 32'(m_wen), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_wen", 32'(m_wen), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_addr", m_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    repeat (5) @(negedge clk);
    chk("no_resume_busy", 32'(busy), 0);
    chk("no_resume_wen", 32'(m_wen), 0);
    send(8'h5A, "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
